// File: rtl/risc_id.sv
// Decode/register-read stage: 32x32 register file, EX/WB forwarding, BZ/JMP/JMR resolution.
// Redirect outputs are combinational (0 cycles); ID/EX register outputs follow IR by 1 cycle; no stalls.
module risc_id #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8,
    parameter int NREG   = 32
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [PC_W-1:0]   PC_1,
    input  logic [31:0]       IR,
    input  logic              ex_we,
    input  logic [4:0]        ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              branch_predict,
    output logic              pc_sel,
    output logic [PC_W-1:0]   pc_target,
    output logic [PC_W-1:0]   PC_2,
    output logic [31:0]       IR_2,
    output logic [4:0]        rd_2,
    output logic [DATA_W-1:0] A_2,
    output logic [DATA_W-1:0] B_2,
    output logic [DATA_W-1:0] imm_2,
    output logic              we_2
);
    localparam logic [6:0] OP_NOP = 7'd0,  OP_ADD = 7'd1,  OP_SUB = 7'd2,  OP_AND = 7'd3;
    localparam logic [6:0] OP_OR  = 7'd4,  OP_XOR = 7'd5,  OP_NOT = 7'd6,  OP_MOV = 7'd7;
    localparam logic [6:0] OP_ADI = 7'd8,  OP_AIU = 7'd9,  OP_LSL = 7'd10, OP_LSR = 7'd11;
    localparam logic [6:0] OP_BZ  = 7'd12, OP_JMP = 7'd13, OP_JMR = 7'd14;

    logic [DATA_W-1:0] r_rf [NREG];
    logic [PC_W-1:0]   r_pc_2;
    logic [31:0]       r_ir_2;
    logic [4:0]        r_rd_2;
    logic [DATA_W-1:0] r_a_2, r_b_2, r_imm_2;
    logic              r_we_2;

    logic [6:0]        w_op;
    logic [4:0]        w_rd, w_rs, w_rt;
    logic [14:0]       w_imm15;
    logic [DATA_W-1:0] w_rs_val, w_rt_val, w_imm, w_b;
    logic              w_we, w_taken;
    logic [PC_W-1:0]   w_target;

    assign w_op    = IR[31:25];
    assign w_rd    = IR[24:20];
    assign w_rs    = IR[19:15];
    assign w_rt    = IR[14:10];
    assign w_imm15 = IR[14:0];

    // EX beats WB; WB beats the array so a same-cycle write is visible to the reader.
    function automatic logic [DATA_W-1:0] fwd(input logic [4:0] idx);
        if (idx == 5'd0)
            return '0;
        else if (ex_we && ex_rd == idx)
            return ex_data;
        else if (wb_we && wb_rd == idx)
            return wb_data;
        else
            return r_rf[idx];
    endfunction

    always_comb begin
        w_rs_val = fwd(w_rs);
        w_rt_val = fwd(w_rt);

        w_imm = {{(DATA_W-15){w_imm15[14]}}, w_imm15};
        case (w_op)
            OP_AIU:         w_imm = {{(DATA_W-15){1'b0}}, w_imm15};
            OP_LSL, OP_LSR: w_imm = {{(DATA_W-5){1'b0}}, IR[4:0]};
            default:        ;
        endcase

        case (w_op)
            OP_ADI, OP_AIU, OP_LSL, OP_LSR: w_b = w_imm;
            default:                        w_b = w_rt_val;
        endcase

        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV,
            OP_ADI, OP_AIU, OP_LSL, OP_LSR: w_we = (w_rd != 5'd0);
            default:                        w_we = 1'b0;
        endcase

        w_taken  = 1'b0;
        w_target = '0;
        case (w_op)
            OP_BZ: begin
                w_taken  = (w_rs_val == '0);
                w_target = PC_1 + w_imm15[PC_W-1:0];
            end
            OP_JMP: begin
                w_taken  = 1'b1;
                w_target = PC_1 + w_imm15[PC_W-1:0];
            end
            OP_JMR: begin
                w_taken  = 1'b1;
                w_target = w_rs_val[PC_W-1:0];
            end
            default: ;
        endcase
        if (reset)
            w_taken = 1'b0;
    end

    assign pc_sel         = w_taken;
    assign branch_predict = ~w_taken;
    assign pc_target      = w_taken ? w_target : '0;

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                r_rf[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0) begin
            r_rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pc_2  <= '0;
            r_ir_2  <= '0;
            r_rd_2  <= '0;
            r_a_2   <= '0;
            r_b_2   <= '0;
            r_imm_2 <= '0;
            r_we_2  <= 1'b0;
        end else begin
            r_pc_2  <= PC_1;
            r_ir_2  <= IR;
            r_rd_2  <= w_we ? w_rd : 5'd0;
            r_a_2   <= w_rs_val;
            r_b_2   <= w_b;
            r_imm_2 <= w_imm;
            r_we_2  <= w_we;
        end
    end

    assign PC_2  = r_pc_2;
    assign IR_2  = r_ir_2;
    assign rd_2  = r_rd_2;
    assign A_2   = r_a_2;
    assign B_2   = r_b_2;
    assign imm_2 = r_imm_2;
    assign we_2  = r_we_2;
endmodule

// File: tb/tb_risc_id.sv
// Directed-vector bench for the decode stage: table of vectors plus reset sequences.
module tb_risc_id;
    localparam logic [6:0] ADD = 7'd1, SUB = 7'd2, NOT = 7'd6, MOV = 7'd7;
    localparam logic [6:0] ADI = 7'd8, AIU = 7'd9, LSL = 7'd10;
    localparam logic [6:0] BZ  = 7'd12, JMP = 7'd13, JMR = 7'd14;
    localparam int NV = 20;

    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  PC_1;
    logic [31:0] IR;
    logic        ex_we, wb_we;
    logic [4:0]  ex_rd, wb_rd;
    logic [31:0] ex_data, wb_data;
    logic        branch_predict, pc_sel, we_2;
    logic [7:0]  pc_target, PC_2;
    logic [31:0] IR_2, A_2, B_2, imm_2;
    logic [4:0]  rd_2;

    int n_chk  = 0;
    int n_fail = 0;

    risc_id dut (
        .CLK(CLK), .reset(reset), .PC_1(PC_1), .IR(IR),
        .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .branch_predict(branch_predict), .pc_sel(pc_sel), .pc_target(pc_target),
        .PC_2(PC_2), .IR_2(IR_2), .rd_2(rd_2), .A_2(A_2), .B_2(B_2),
        .imm_2(imm_2), .we_2(we_2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] ir;
        logic [7:0]  pc1;
        logic        exwe;
        logic [4:0]  exrd;
        logic [31:0] exd;
        logic        wbwe;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        sel;
        logic        bp;
        logic [7:0]  tgt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
    } vec_t;

    vec_t tv [NV];

    function automatic logic [31:0] r3(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 10'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [14:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ir, input logic [7:0] pc1,
                         input logic exwe, input logic [4:0] exrd, input logic [31:0] exd,
                         input logic wbwe, input logic [4:0] wbrd, input logic [31:0] wbd);
        IR = ir; PC_1 = pc1;
        ex_we = exwe; ex_rd = exrd; ex_data = exd;
        wb_we = wbwe; wb_rd = wbrd; wb_data = wbd;
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // fields: ir, pc1, exwe, exrd, exd, wbwe, wbrd, wbd | sel, bp, tgt, a, b, imm, rd, we
        tv[0]  = '{r3(ADD,6,5,5), 8'h01, 0, 0, 0, 1, 5, 32'h1234, 0, 1, 0, 32'h1234, 32'h1234, 32'h1400, 6, 1};
        tv[1]  = '{r3(ADD,1,5,0), 8'h02, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 1, 1};
        tv[2]  = '{r3(SUB,9,0,3), 8'h03, 1, 3, 7, 1, 3, 9, 0, 1, 0, 0, 7, 32'h0C00, 9, 1};
        tv[3]  = '{r3(MOV,2,3,0), 8'h04, 0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0, 2, 1};
        tv[4]  = '{ri(BZ,0,7,2), 8'h08, 0, 0, 0, 0, 0, 0, 1, 0, 8'd10, 0, 0, 2, 0, 0};
        tv[5]  = '{32'h0, 8'h09, 0, 0, 0, 1, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tv[6]  = '{ri(BZ,0,7,2), 8'h08, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 0, 0};
        tv[7]  = '{32'h0, 8'h0A, 0, 0, 0, 1, 16, 23, 0, 1, 0, 0, 0, 0, 0, 0};
        tv[8]  = '{ri(JMR,0,16,0), 8'h0B, 0, 0, 0, 0, 0, 0, 1, 0, 8'd23, 23, 0, 0, 0, 0};
        tv[9]  = '{ri(JMP,0,0,1), 8'hFF, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0};
        tv[10] = '{ri(AIU,16,0,15'h7FFF), 8'h0C, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h7FFF, 32'h7FFF, 16, 1};
        tv[11] = '{ri(ADI,18,0,15'h7FFF), 8'h0D, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 18, 1};
        tv[12] = '{32'h0, 8'h0E, 0, 0, 0, 1, 0, 32'hDEAD, 0, 1, 0, 0, 0, 0, 0, 0};
        tv[13] = '{r3(MOV,4,0,0), 8'h0F, 0, 0, 0, 1, 0, 32'h55, 0, 1, 0, 0, 0, 0, 4, 1};
        tv[14] = '{ri(LSL,10,5,3), 8'h10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234, 3, 3, 10, 1};
        tv[15] = '{ri(JMP,5,0,15'h7FFE), 8'h10, 0, 0, 0, 0, 0, 0, 1, 0, 8'h0E, 0, 0, 32'hFFFFFFFE, 0, 0};
        tv[16] = '{r3(NOT,11,5,0), 8'h11, 1, 5, 32'hAAAA, 1, 5, 32'hBBBB, 0, 1, 0, 32'hAAAA, 0, 0, 11, 1};
        tv[17] = '{r3(ADD,12,5,5), 8'h12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hBBBB, 32'hBBBB, 32'h1400, 12, 1};
        tv[18] = '{ri(JMR,0,8,0), 8'h13, 1, 8, 32'h10042, 0, 0, 0, 1, 0, 8'h42, 32'h10042, 0, 0, 0, 0};
        tv[19] = '{ri(BZ,0,5,3), 8'hFE, 1, 5, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0, 3, 0, 0};

        // Reset for two cycles with a would-be-taken branch on IR.
        reset = 1'b1;
        drive(ri(BZ,0,0,4), 8'h40, 0, 0, 0, 1, 9, 32'h99);
        step;
        check("rst_pc_sel", {31'd0, pc_sel}, 0);
        check("rst_bp", {31'd0, branch_predict}, 1);
        step;
        check("rst_A_2", A_2, 0);
        check("rst_IR_2", IR_2, 0);
        check("rst_we_2", {31'd0, we_2}, 0);
        check("rst_PC_2", {24'd0, PC_2}, 0);
        reset = 1'b0;
        drive(32'h0, 8'h00, 0, 0, 0, 0, 0, 0);

        for (int r = 1; r < 32; r++) begin
            IR = r3(MOV, 1, r[4:0], 0);
            #4;
            check("init_pc_sel", {31'd0, pc_sel}, 0);
            check("init_bp", {31'd0, branch_predict}, 1);
            step;
            check($sformatf("init_R%0d", r), A_2, 0);
        end

        for (int i = 0; i < NV; i++) begin
            drive(tv[i].ir, tv[i].pc1, tv[i].exwe, tv[i].exrd, tv[i].exd,
                  tv[i].wbwe, tv[i].wbrd, tv[i].wbd);
            #4;
            check($sformatf("v%0d_pc_sel", i), {31'd0, pc_sel}, {31'd0, tv[i].sel});
            check($sformatf("v%0d_bp", i), {31'd0, branch_predict}, {31'd0, tv[i].bp});
            check($sformatf("v%0d_target", i), {24'd0, pc_target}, {24'd0, tv[i].tgt});
            step;
            check($sformatf("v%0d_A_2", i), A_2, tv[i].a);
            check($sformatf("v%0d_B_2", i), B_2, tv[i].b);
            check($sformatf("v%0d_imm_2", i), imm_2, tv[i].imm);
            check($sformatf("v%0d_rd_2", i), {27'd0, rd_2}, {27'd0, tv[i].rd});
            check($sformatf("v%0d_we_2", i), {31'd0, we_2}, {31'd0, tv[i].we});
            check($sformatf("v%0d_IR_2", i), IR_2, tv[i].ir);
            check($sformatf("v%0d_PC_2", i), {24'd0, PC_2}, {24'd0, tv[i].pc1});
        end

        // Mid-stream reset: clears the array and pipeline, drops a concurrent WB write.
        drive(32'h0, 8'h20, 0, 0, 0, 1, 20, 32'h77);
        step;
        drive(r3(ADD,13,20,20), 8'h21, 0, 0, 0, 0, 0, 0);
        step;
        check("pre_rst_A_2", A_2, 32'h77);
        reset = 1'b1;
        drive(ri(BZ,0,0,5), 8'h22, 0, 0, 0, 1, 21, 32'h5);
        #4;
        check("mid_rst_pc_sel", {31'd0, pc_sel}, 0);
        check("mid_rst_bp", {31'd0, branch_predict}, 1);
        check("mid_rst_target", {24'd0, pc_target}, 0);
        step;
        check("mid_rst_IR_2", IR_2, 0);
        check("mid_rst_A_2", A_2, 0);
        check("mid_rst_rd_2", {27'd0, rd_2}, 0);
        reset = 1'b0;
        drive(r3(MOV,1,20,0), 8'h23, 0, 0, 0, 0, 0, 0);
        step;
        check("post_rst_R20", A_2, 0);
        drive(r3(MOV,1,21,0), 8'h24, 0, 0, 0, 0, 0, 0);
        step;
        check("post_rst_R21", A_2, 0);
        drive(r3(MOV,1,5,0), 8'h25, 0, 0, 0, 0, 0, 0);
        step;
        check("post_rst_R5", A_2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, expected completion");
        $fatal(1);
    end
endmodule
